// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding, error codes and address decode helper for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam int DEF_DEPTH = 1024;
  localparam int ADDR_W = $clog2(DEF_DEPTH);
  // Anything above the word index of a DEPTH-word array is out of range.
  function automatic logic [1:0] err_code(input logic [31:0] addr, input int aw);
    return (addr[1:0] != 2'b00 ? ERR_MISALIGN : 2'b00) |
           ((addr >> (aw + 2)) != 32'd0 ? ERR_RANGE : 2'b00);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 synchronous RAM with byte-lane writes and registered read data
//   clock        posedge clock
//   en           access strobe (read when we=0, write when we=1)
//   we, be       write enable and per-byte lane enables
//   idx, wdata   word index and write data
//   rdata        read data, updated only by reads
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end else
        rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with configurable access latency, one request in flight
//   clock, reset_n                    clock and asynchronous active-low reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata/req_be  request fields, sampled on accept
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata/rsp_err                 load data (0 for stores/errors) and error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic lat_write;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0] lat_be;
  logic a_write;
  logic [31:0] a_addr, a_wdata;
  logic [3:0] a_be;
  logic [1:0] a_err;
  logic accept, access, rsp_zero;
  logic [31:0] arr_rdata;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  // With LATENCY 1 the access happens on the accept edge straight from the request inputs;
  // otherwise it happens from the latched request on the last BUSY cycle.
  assign access = reset_n && (LATENCY == 1 ? accept : state == BUSY && cnt == CW'(1));
  assign a_write = state == IDLE ? req_write : lat_write;
  assign a_addr = state == IDLE ? req_addr : lat_addr;
  assign a_wdata = state == IDLE ? req_wdata : lat_wdata;
  assign a_be = state == IDLE ? req_be : lat_be;
  assign a_err = err_code(a_addr, AW);
  // The RAM output register holds the last load; stores and errors mask it to zero.
  assign rsp_rdata = rsp_zero ? 32'd0 : arr_rdata;
  always_comb
    state_nx = accept ? (LATENCY == 1 ? RESP : BUSY) :
               access ? RESP :
               rsp_valid && rsp_ready ? IDLE : state;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      lat_write <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_be <= '0;
      rsp_err <= 1'b0;
      rsp_zero <= 1'b1;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_write <= req_write;
        lat_addr <= req_addr;
        lat_wdata <= req_wdata;
        lat_be <= req_be;
        cnt <= CW'(LATENCY - 1);
      end else if (state == BUSY)
        cnt <= cnt - 1'b1;
      if (access) begin
        rsp_err <= |a_err;
        rsp_zero <= a_write || |a_err;
      end
    end
  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clock (clock),
    .en    (access && a_err == 2'b00),
    .we    (a_write),
    .be    (a_be),
    .idx   (a_addr[AW+1:2]),
    .wdata (a_wdata),
    .rdata (arr_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a transaction-level memory model
module tb_dmem_responder;
  localparam int LAT = 2;
  localparam int DEPTH = 1024;
  localparam int DEPTH1 = 16;
  logic clock = 0, reset_n = 0;
  logic req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_be = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic req_valid1 = 0, req_write1 = 0, rsp_ready1 = 0;
  logic [31:0] req_addr1 = 0, req_wdata1 = 0;
  logic [3:0] req_be1 = 0;
  logic req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;
  always #5 clock = ~clock;
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u0 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  dmem_responder #(.DEPTH(DEPTH1), .LATENCY(1)) u1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic w; logic [31:0] a; logic [31:0] d; logic [3:0] be; int due;} req_t;
  req_t q[$];
  logic [31:0] mm [DEPTH];
  logic [31:0] e_rd;
  logic e_err;
  bit done, idle;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic timeout(input string n, input int waited);
    checks++;
    errors++;
    $display("FAIL %s: waited %0d cycles, limit 50", n, waited);
  endtask
  // Memory semantics: the response reflects the word state after any earlier completed store.
  function automatic void model_resp(input req_t r);
    if (r.a[1:0] != 2'b00 || r.a >= 32'(DEPTH * 4)) begin
      e_rd = 0;
      e_err = 1;
    end else begin
      e_err = 0;
      e_rd = 0;
      if (r.w) begin
        for (int i = 0; i < 4; i++)
          if (r.be[i]) mm[r.a / 4][8*i +: 8] = r.d[8*i +: 8];
      end else
        e_rd = mm[r.a / 4];
    end
  endfunction
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      q.delete();
      done = 0;
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_req_ready", 32'(req_ready), 1);
      chk("reset_rdata", rsp_rdata, 0);
      chk("reset_err", 32'(rsp_err), 0);
    end else begin
      idle = q.size() == 0;
      if (!idle && !done && cyc >= q[0].due) begin
        model_resp(q[0]);
        done = 1;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(done));
      chk("req_ready", 32'(req_ready), 32'(idle));
      if (done && rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
      end
      if (done && rsp_ready) begin
        void'(q.pop_front());
        done = 0;
      end
      if (idle && req_valid) q.push_back('{req_write, req_addr, req_wdata, req_be, cyc + LAT});
    end
  end
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input int hold, output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(posedge clock); #1;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    n = 0;
    do begin @(negedge clock); n++; end while (!req_ready && n < 50);
    if (!req_ready) timeout("accept", n);
    @(posedge clock); #1;
    req_valid = 0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clock); n++; end
    if (!rsp_valid) timeout("response", n);
    rd = rsp_rdata; e = rsp_err; lat = n;
    repeat (hold) @(negedge clock);
    @(posedge clock); #1 rsp_ready = 1;
    @(posedge clock); #1 rsp_ready = 0;
  endtask
  task automatic set1(input int i);
    req_valid1 = i < 16;
    req_write1 = i < 8;
    req_addr1 = 32'((i % 8) * 4);
    req_wdata1 = 32'h0101_0101 * 32'(i + 1);
    req_be1 = 4'hF;
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd, a;
    logic e;
    int lat, n;
    foreach (mm[i]) mm[i] = 0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1;
    @(posedge clock); #1;
    req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
    @(negedge clock);
    @(posedge clock); #1;
    req_valid = 0;
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    xact(0, 32'h10, 0, 4'hF, 0, rd, e, lat);
    chk("t1_load_after_reset", rd, 0);
    xact(1, 32'h40, 32'h12345678, 4'hF, 0, rd, e, lat);
    chk("t2_store_lat", lat, 2);
    chk("t2_store_err", 32'(e), 0);
    xact(0, 32'h40, 0, 4'h0, 0, rd, e, lat);
    chk("t2_load_lat", lat, 2);
    chk("t2_load_data", rd, 32'h12345678);
    xact(1, 32'h40, 32'hAABBCCDD, 4'b0101, 0, rd, e, lat);
    xact(0, 32'h40, 0, 4'h0, 0, rd, e, lat);
    chk("t3_byte_lanes", rd, 32'h12BB56DD);
    xact(0, 32'h42, 0, 4'h0, 0, rd, e, lat);
    chk("t4_misalign_err", 32'(e), 1);
    chk("t4_misalign_data", rd, 0);
    xact(1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd, e, lat);
    xact(1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, 0, rd, e, lat);
    chk("t4_range_err", 32'(e), 1);
    chk("t4_range_lat", lat, 2);
    xact(0, 32'h0, 0, 4'h0, 0, rd, e, lat);
    chk("t4_word0_kept", rd, 32'hCAFEF00D);
    xact(1, 32'(DEPTH * 4 - 4), 32'h5A5A0001, 4'hF, 0, rd, e, lat);
    xact(0, 32'(DEPTH * 4 - 4), 0, 4'h0, 0, rd, e, lat);
    chk("t4_last_word", rd, 32'h5A5A0001);
    xact(0, 32'h40, 0, 4'h0, 5, rd, e, lat);
    chk("t5_backpressure_data", rd, 32'h12BB56DD);
    xact(1, 32'h40, 32'hFFFFFFFF, 4'b0000, 0, rd, e, lat);
    chk("be0_store_err", 32'(e), 0);
    xact(0, 32'h40, 0, 4'h0, 0, rd, e, lat);
    chk("be0_store_noop", rd, 32'h12BB56DD);
    repeat (150) begin
      a = $urandom_range(0, 9) == 0 ? $urandom :
          32'($urandom_range(0, 15) * 4 + ($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0));
      xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), rd, e, lat);
      chk("rand_lat", lat, LAT);
    end
    @(posedge clock); #1;
    rsp_ready1 = 1;
    set1(0);
    for (int i = 0; i < 16; i++) begin
      n = 0;
      do begin @(negedge clock); n++; end while (!req_ready1 && n < 50);
      if (!req_ready1) timeout("l1_accept", n);
      chk("l1_accept_gap", n, 1);
      @(posedge clock); #1 set1(i + 1);
      @(negedge clock);
      chk("l1_rsp_valid", 32'(rsp_valid1), 1);
      chk("l1_rdata", rsp_rdata1, i < 8 ? 32'd0 : 32'h0101_0101 * 32'(i - 7));
      chk("l1_err", 32'(rsp_err1), 0);
    end
    @(posedge clock); #1 rsp_ready1 = 0;
    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
